// File: rtl/add_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : add_accumulator (with calculator_pkg)
//  Brief    : Sequential operand accumulator in front of a 32-bit adder;
//             valid/ready operand stream in, valid/ready result out.
//  Revision : 1.0
// ============================================================================

package calculator_pkg;
    localparam int DATA_W = 32;
endpackage

module add_accumulator
    import calculator_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              op_valid_i,
    output logic              op_ready_o,
    input  logic [DATA_W-1:0] op_data_i,
    input  logic              op_last_i,
    output logic [DATA_W-1:0] add_a_o,
    output logic [DATA_W-1:0] add_b_o,
    input  logic [DATA_W-1:0] add_sum_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [DATA_W-1:0] res_data_o,
    output logic [CNT_W-1:0]  res_count_o,
    output logic              res_ovf_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [DATA_W-1:0] r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ovf;

    logic w_op_accept;
    logic w_res_xfer;

    assign w_op_accept = op_valid_i & op_ready_o;
    assign w_res_xfer  = res_valid_o & res_ready_i;

    assign add_a_o     = r_acc;
    assign add_b_o     = op_data_i;
    assign res_data_o  = r_acc;
    assign res_count_o = r_cnt;
    assign res_ovf_o   = r_ovf;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear_i) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_ACCUM: begin
                    if (w_op_accept) begin
                        w_state_nxt = op_last_i ? S_DONE : S_ACCUM;
                    end
                end
                S_DONE: begin
                    if (w_res_xfer) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        op_ready_o  = 1'b0;
        res_valid_o = 1'b0;
        case (r_state)
            S_IDLE, S_ACCUM: op_ready_o  = 1'b1;
            S_DONE:          res_valid_o = 1'b1;
            default: begin
                op_ready_o  = 1'b0;
                res_valid_o = 1'b0;
            end
        endcase
    end

    // Abort and result hand-off both leave IDLE's all-zero register image.
    // The adder has no carry output, so a wrapped sum is detected by it
    // coming out smaller than the running total it started from.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (clear_i || w_res_xfer) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_op_accept) begin
            r_acc <= add_sum_i;
            if (r_cnt != c_CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_ovf <= r_ovf | (add_sum_i < r_acc);
        end
    end

endmodule
`default_nettype wire
